// File: rtl/minipic_pkg.sv
// rtl/minipic_pkg.sv - shared types and sizing helpers for the minipic interrupt controller
package minipic_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ASSERT = 2'd1,
    GAP    = 2'd2
  } state_t;

  localparam int NUM_IRQ_MAX = 16;

  // irq_id keeps at least one bit so a single-source build still has a port
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/minipic_irq_edge_latch.sv
// rtl/minipic_irq_edge_latch.sv - per-source rising-edge detect with sticky pending and overrun bits
module irq_edge_latch (
  input  logic clk,
  input  logic rst,
  input  logic irq_in,
  input  logic ack_clr,
  input  logic overrun_clr,
  output logic pending,
  output logic overrun
);

  logic prev;
  logic evt;
  logic ovr_set;

  assign evt     = irq_in & ~prev;
  // an event landing on the acknowledging edge simply re-pends; it is not an overrun
  assign ovr_set = evt & pending & ~ack_clr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev    <= 1'b0;
      pending <= 1'b0;
      overrun <= 1'b0;
    end else begin
      prev <= irq_in;

      if (evt)
        pending <= 1'b1;
      else if (ack_clr)
        pending <= 1'b0;

      if (ovr_set)
        overrun <= 1'b1;
      else if (overrun_clr)
        overrun <= 1'b0;
    end
  end

endmodule

// File: rtl/minipic.sv
// rtl/minipic.sv - fixed-priority interrupt controller with mask and irq/ack handshake
module minipic
  import minipic_pkg::*;
#(
  parameter  int NUM_IRQ = 4,
  localparam int ID_W    = id_width(NUM_IRQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_IRQ-1:0] irq_in,
  input  logic               mask_we,
  input  logic [NUM_IRQ-1:0] mask_wdata,
  output logic [NUM_IRQ-1:0] mask,
  output logic [NUM_IRQ-1:0] pending,
  output logic [NUM_IRQ-1:0] overrun,
  input  logic [NUM_IRQ-1:0] overrun_clr,
  output logic               irq_out,
  output logic [ID_W-1:0]    irq_id,
  input  logic               irq_ack
);

  state_t             state;
  logic [NUM_IRQ-1:0] req;
  logic [NUM_IRQ-1:0] ack_clr;
  logic [ID_W-1:0]    sel_id;
  logic               ack_take;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      mask <= '0;
    else if (mask_we)
      mask <= mask_wdata;
  end

  assign ack_take = (state == ASSERT) && irq_ack;

  genvar g;
  generate
    for (g = 0; g < NUM_IRQ; g++) begin : g_src
      assign ack_clr[g] = ack_take && (irq_id == ID_W'(g));

      irq_edge_latch u_latch (
        .clk         (clk),
        .rst         (rst),
        .irq_in      (irq_in[g]),
        .ack_clr     (ack_clr[g]),
        .overrun_clr (overrun_clr[g]),
        .pending     (pending[g]),
        .overrun     (overrun[g])
      );
    end
  endgenerate

  assign req = pending & mask;

  // walk downward so the lowest set index is the one left standing
  always_comb begin
    sel_id = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (req[i])
        sel_id = ID_W'(i);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      irq_out <= 1'b0;
      irq_id  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|req) begin
            irq_id  <= sel_id;
            irq_out <= 1'b1;
            state   <= ASSERT;
          end
        end
        ASSERT: begin
          if (irq_ack) begin
            irq_out <= 1'b0;
            state   <= GAP;
          end
        end
        GAP: begin
          irq_out <= 1'b0;
          state   <= IDLE;
        end
        default: begin
          irq_out <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_minipic.sv
// tb/tb_minipic.sv - directed self-checking bench for minipic
module tb_minipic;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] irq_in;
  logic       mask_we;
  logic [3:0] mask_wdata;
  logic [3:0] mask;
  logic [3:0] pending;
  logic [3:0] overrun;
  logic [3:0] overrun_clr;
  logic       irq_out;
  logic [1:0] irq_id;
  logic       irq_ack;

  int tests_run = 0;
  int tests_failed = 0;

  minipic #(.NUM_IRQ(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .irq_in      (irq_in),
    .mask_we     (mask_we),
    .mask_wdata  (mask_wdata),
    .mask        (mask),
    .pending     (pending),
    .overrun     (overrun),
    .overrun_clr (overrun_clr),
    .irq_out     (irq_out),
    .irq_id      (irq_id),
    .irq_ack     (irq_ack)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // inputs change and outputs are sampled 1 time unit after each rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_mask(input logic [3:0] m);
    mask_we    = 1'b1;
    mask_wdata = m;
    tick();
    mask_we    = 1'b0;
  endtask

  task automatic pulse(input logic [3:0] v);
    irq_in = v;
    tick();
    irq_in = 4'h0;
  endtask

  task automatic do_ack();
    irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; irq_in = 4'h0; mask_we = 1'b0; mask_wdata = 4'h0;
    overrun_clr = 4'h0; irq_ack = 1'b0;

    // reset holds everything at zero even with all lines high
    tick();
    irq_in = 4'hF;
    tick(); tick();
    chk("rst_mask",    32'(mask),    0);
    chk("rst_pending", 32'(pending), 0);
    chk("rst_overrun", 32'(overrun), 0);
    chk("rst_irq_out", 32'(irq_out), 0);
    chk("rst_irq_id",  32'(irq_id),  0);
    rst = 1'b0;
    tick();
    chk("rst_release_pending", 32'(pending), 32'hF);
    chk("rst_release_no_irq",  32'(irq_out), 0);
    irq_in = 4'h0;
    do_reset();

    // single source
    write_mask(4'b0100);
    pulse(4'b0100);
    chk("single_pending", 32'(pending), 32'h4);
    chk("single_not_yet", 32'(irq_out), 0);
    tick();
    chk("single_irq_out", 32'(irq_out), 1);
    chk("single_irq_id",  32'(irq_id),  2);
    do_ack();
    chk("single_ack_pending", 32'(pending), 0);
    chk("single_ack_out",     32'(irq_out), 0);
    tick();
    chk("single_gap_out", 32'(irq_out), 0);
    tick();
    chk("single_idle_out", 32'(irq_out), 0);

    // priority: src1 beats src3
    write_mask(4'hF);
    pulse(4'b1010);
    chk("prio_pending", 32'(pending), 32'hA);
    tick();
    chk("prio_first_out", 32'(irq_out), 1);
    chk("prio_first_id",  32'(irq_id),  1);
    do_ack();
    chk("prio_ack1_out",     32'(irq_out), 0);
    chk("prio_ack1_pending", 32'(pending), 32'h8);
    tick();
    chk("prio_gap_out", 32'(irq_out), 0);
    tick();
    chk("prio_second_out", 32'(irq_out), 1);
    chk("prio_second_id",  32'(irq_id),  3);
    do_ack();
    chk("prio_done_pending", 32'(pending), 0);
    tick(); tick();

    // overrun and set-wins on the ack edge
    pulse(4'b0001);
    chk("ovr_pending", 32'(pending), 32'h1);
    tick();
    chk("ovr_req_out", 32'(irq_out), 1);
    chk("ovr_req_id",  32'(irq_id),  0);
    pulse(4'b0001);
    chk("ovr_set",         32'(overrun), 32'h1);
    chk("ovr_still_pend",  32'(pending), 32'h1);
    tick();
    irq_in = 4'b0001;
    irq_ack = 1'b1;
    tick();
    irq_in = 4'h0;
    irq_ack = 1'b0;
    chk("setwins_pending", 32'(pending), 32'h1);
    chk("setwins_out",     32'(irq_out), 0);
    tick(); tick();
    chk("setwins_rereq_out", 32'(irq_out), 1);
    chk("setwins_rereq_id",  32'(irq_id),  0);
    overrun_clr = 4'b0001;
    tick();
    overrun_clr = 4'h0;
    chk("ovr_clr", 32'(overrun), 0);
    do_ack();
    chk("ovr_done_pending", 32'(pending), 0);
    tick(); tick();

    // masked source latches but never requests
    write_mask(4'h0);
    pulse(4'b0010);
    chk("mask_pending", 32'(pending), 32'h2);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("mask_quiet", 32'(irq_out), 0);
    end
    write_mask(4'b0010);
    tick();
    chk("unmask_out", 32'(irq_out), 1);
    chk("unmask_id",  32'(irq_id),  1);
    write_mask(4'h0);
    chk("remask_keep_out", 32'(irq_out), 1);
    tick();
    chk("remask_keep_out2", 32'(irq_out), 1);
    chk("remask_keep_id",   32'(irq_id),  1);

    // asynchronous reset mid-ASSERT
    #2 rst = 1'b1;
    #1;
    chk("async_rst_out",     32'(irq_out), 0);
    chk("async_rst_pending", 32'(pending), 0);
    chk("async_rst_mask",    32'(mask),    0);
    tick();
    rst = 1'b0;

    // stray ack in IDLE changes nothing
    pulse(4'b0100);
    chk("stray_pre_pending", 32'(pending), 32'h4);
    do_ack();
    chk("stray_pending", 32'(pending), 32'h4);
    chk("stray_out",     32'(irq_out), 0);
    write_mask(4'b0100);
    tick();
    chk("stray_then_req_out", 32'(irq_out), 1);
    chk("stray_then_req_id",  32'(irq_id),  2);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
